layer_sequencer: RTL and testbench

Forward-pass sequencer for the multiplexed neuron layer. It accepts one input activation vector and iterates it through LAYER_MAX layers. For each layer it issues the layer number to the weight fetch, feeds activations to the shared layer module, and converts returned neuron sums to activations (shift, ReLU, saturate). It keeps every layer's activation vector in an internal buffer for the backpropagation path, and emits the final-layer activations on a result handshake.

---
 rtl/layer_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_layer_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Purpose  : Forward-pass sequencer: iterates one activation vector through
//            LAYER_MAX layers and buffers every layer's activations.
//            Optional macro PERF_COUNTER_EN adds the cycle_count port.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int NEURON_NUM          = 5,
    parameter int NEURON_OUTPUT_WIDTH = 12,
    parameter int ACTIVATION_WIDTH    = 9,
    parameter int OUTPUT_SHIFT        = 2,
    parameter int LAYER_ADDR_WIDTH    = 2,
    parameter int LAYER_MAX           = 3
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]     start_inputs,
    input  logic                                       start_inputs_valid,
    output logic                                       start_inputs_ready,
    output logic [LAYER_ADDR_WIDTH-1:0]                layer_number,
    output logic                                       layer_number_valid,
    input  logic                                       layer_number_ready,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]     layer_inputs,
    output logic                                       layer_inputs_valid,
    input  logic                                       layer_inputs_ready,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]  layer_outputs,
    input  logic                                       layer_outputs_valid,
    output logic                                       layer_outputs_ready,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]     result,
    output logic                                       result_valid,
    input  logic                                       result_ready,
    input  logic [LAYER_ADDR_WIDTH-1:0]                act_rd_addr,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]     act_rd_data,
    output logic                                       busy
`ifdef PERF_COUNTER_EN
    ,
    output logic [31:0]                                cycle_count
`endif
);

    localparam int c_VEC_W   = NEURON_NUM * ACTIVATION_WIDTH;
    localparam int c_ACT_MAX = 2**ACTIVATION_WIDTH - 1;
    localparam logic [LAYER_ADDR_WIDTH-1:0] c_LAST     = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
    localparam logic [LAYER_ADDR_WIDTH-1:0] c_TOP_ADDR = LAYER_ADDR_WIDTH'(LAYER_MAX);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]                  r_state;
    logic [LAYER_ADDR_WIDTH-1:0] r_layer;
    logic                        r_ln_valid;
    logic                        r_li_valid;
    logic                        r_res_valid;
    logic [c_VEC_W-1:0]          r_layer_in;
    logic [c_VEC_W-1:0]          r_result;
    logic [c_VEC_W-1:0]          r_rd_data;
    logic [c_VEC_W-1:0]          r_buf [0:LAYER_MAX];
    logic [c_VEC_W-1:0]          w_act;

    logic w_start_fire;
    logic w_ln_fire;
    logic w_li_fire;
    logic w_out_fire;
    logic w_res_fire;
    logic w_issue_done;

    // Shift, then clamp into [0, 2^ACTIVATION_WIDTH-1]
    function automatic logic [ACTIVATION_WIDTH-1:0] to_act(
        input logic [NEURON_OUTPUT_WIDTH-1:0] sum
    );
        logic signed [NEURON_OUTPUT_WIDTH-1:0] sh;
        int                                    v;
        sh = $signed(sum) >>> OUTPUT_SHIFT;
        v  = int'(sh);
        if (v < 0)
            to_act = '0;
        else if (v > c_ACT_MAX)
            to_act = '1;
        else
            to_act = v[ACTIVATION_WIDTH-1:0];
    endfunction

    generate
        for (genvar i = 0; i < NEURON_NUM; i++) begin : g_lane
            assign w_act[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] =
                to_act(layer_outputs[i*NEURON_OUTPUT_WIDTH +: NEURON_OUTPUT_WIDTH]);
        end
    endgenerate

    assign w_start_fire = (r_state == c_IDLE) && start_inputs_valid;
    assign w_ln_fire    = r_ln_valid && layer_number_ready;
    assign w_li_fire    = r_li_valid && layer_inputs_ready;
    assign w_out_fire   = (r_state == c_WAIT) && layer_outputs_valid;
    assign w_res_fire   = r_res_valid && result_ready;
    // Both issue handshakes finished, counting ones completing this cycle
    assign w_issue_done = (!r_ln_valid || w_ln_fire) && (!r_li_valid || w_li_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_layer     <= '0;
            r_ln_valid  <= 1'b0;
            r_li_valid  <= 1'b0;
            r_res_valid <= 1'b0;
            r_layer_in  <= '0;
            r_result    <= '0;
            r_rd_data   <= '0;
            for (int k = 0; k <= LAYER_MAX; k++)
                r_buf[k] <= '0;
        end else begin
            // Read samples the array before any write this cycle lands
            r_rd_data <= (act_rd_addr <= c_TOP_ADDR) ? r_buf[act_rd_addr] : '0;

            case (r_state)
                c_IDLE: begin
                    if (w_start_fire) begin
                        r_buf[0]   <= start_inputs;
                        r_layer_in <= start_inputs;
                        r_layer    <= '0;
                        r_ln_valid <= 1'b1;
                        r_li_valid <= 1'b1;
                        r_state    <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_ln_fire)
                        r_ln_valid <= 1'b0;
                    if (w_li_fire)
                        r_li_valid <= 1'b0;
                    if (w_issue_done)
                        r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_out_fire) begin
                        r_buf[r_layer + LAYER_ADDR_WIDTH'(1)] <= w_act;
                        r_layer_in <= w_act;
                        if (r_layer == c_LAST) begin
                            r_result    <= w_act;
                            r_res_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_layer    <= r_layer + LAYER_ADDR_WIDTH'(1);
                            r_ln_valid <= 1'b1;
                            r_li_valid <= 1'b1;
                            r_state    <= c_ISSUE;
                        end
                    end
                end
                c_DONE: begin
                    if (w_res_fire) begin
                        r_res_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef PERF_COUNTER_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cycle_count <= '0;
        else if (w_start_fire)
            r_cycle_count <= '0;
        else if ((r_state != c_IDLE) && (r_cycle_count != 32'hFFFF_FFFF))
            r_cycle_count <= r_cycle_count + 32'd1;
    end

    assign cycle_count = r_cycle_count;
`endif

    assign start_inputs_ready  = (r_state == c_IDLE);
    assign layer_outputs_ready = (r_state == c_WAIT);
    assign layer_number        = r_layer;
    assign layer_number_valid  = r_ln_valid;
    assign layer_inputs        = r_layer_in;
    assign layer_inputs_valid  = r_li_valid;
    assign result              = r_result;
    assign result_valid        = r_res_valid;
    assign act_rd_data         = r_rd_data;
    assign busy                = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Purpose  : Directed self-checking bench for layer_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam int NN  = 5;
    localparam int NOW = 12;
    localparam int AW  = 9;
    localparam int LAW = 2;
    localparam int VW  = NN * AW;
    localparam int SW  = NN * NOW;

    logic            clk = 1'b0;
    logic            rst;
    logic [VW-1:0]   start_inputs;
    logic            start_inputs_valid;
    logic            start_inputs_ready;
    logic [LAW-1:0]  layer_number;
    logic            layer_number_valid;
    logic            layer_number_ready;
    logic [VW-1:0]   layer_inputs;
    logic            layer_inputs_valid;
    logic            layer_inputs_ready;
    logic [SW-1:0]   layer_outputs;
    logic            layer_outputs_valid;
    logic            layer_outputs_ready;
    logic [VW-1:0]   result;
    logic            result_valid;
    logic            result_ready;
    logic [LAW-1:0]  act_rd_addr;
    logic [VW-1:0]   act_rd_data;
    logic            busy;
`ifdef PERF_COUNTER_EN
    logic [31:0]     cycle_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_inputs        (start_inputs),
        .start_inputs_valid  (start_inputs_valid),
        .start_inputs_ready  (start_inputs_ready),
        .layer_number        (layer_number),
        .layer_number_valid  (layer_number_valid),
        .layer_number_ready  (layer_number_ready),
        .layer_inputs        (layer_inputs),
        .layer_inputs_valid  (layer_inputs_valid),
        .layer_inputs_ready  (layer_inputs_ready),
        .layer_outputs       (layer_outputs),
        .layer_outputs_valid (layer_outputs_valid),
        .layer_outputs_ready (layer_outputs_ready),
        .result              (result),
        .result_valid        (result_valid),
        .result_ready        (result_ready),
        .act_rd_addr         (act_rd_addr),
        .act_rd_data         (act_rd_data),
        .busy                (busy)
`ifdef PERF_COUNTER_EN
        ,
        .cycle_count         (cycle_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Lane 4 is the leftmost argument, lane 0 the rightmost
    function automatic logic [VW-1:0] av(input int a, input int b, input int c, input int d, input int e);
        return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e)};
    endfunction

    function automatic logic [SW-1:0] sv(input int a, input int b, input int c, input int d, input int e);
        return {12'(a), 12'(b), 12'(c), 12'(d), 12'(e)};
    endfunction

    logic [VW-1:0] exp_buf [0:3];
    int            cyc;

    initial begin
        rst = 1'b0;
        start_inputs = '0;        start_inputs_valid  = 1'b0;
        layer_number_ready = 1'b0; layer_inputs_ready = 1'b0;
        layer_outputs = '0;       layer_outputs_valid = 1'b0;
        result_ready = 1'b0;      act_rd_addr = '0;

        exp_buf[0] = av(5, 4, 3, 2, 1);
        exp_buf[1] = av(0, 0, 0, 500, 375);
        exp_buf[2] = av(511, 0, 1, 256, 0);
        exp_buf[3] = av(2, 2, 511, 511, 0);

        repeat (2) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start_rdy", 64'(start_inputs_ready), 64'd1);
        check("rst_valids", 64'({layer_number_valid, layer_inputs_valid, result_valid}), 64'd0);
        check("rst_layer", 64'(layer_number), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_rd", 64'(act_rd_data), 64'd0);
        rst = 1'b1;
        tick();

        // ---- pass 1: layer 0 with number accepted before inputs
        start_inputs = av(5, 4, 3, 2, 1); start_inputs_valid = 1'b1;
        tick();
        start_inputs_valid = 1'b0;
        check("p1_start_rdy", 64'(start_inputs_ready), 64'd0);
        check("p1_busy", 64'(busy), 64'd1);
        check("p1_l0_num", 64'(layer_number), 64'd0);
        check("p1_l0_valids", 64'({layer_number_valid, layer_inputs_valid}), 64'd3);
        check("p1_l0_in", 64'(layer_inputs), 64'(av(5, 4, 3, 2, 1)));
        layer_number_ready = 1'b1;
        tick();
        layer_number_ready = 1'b0;
        check("p1_l0_ln_drop", 64'({layer_number_valid, layer_inputs_valid}), 64'd1);
        // sums offered during ISSUE must be left alone
        layer_outputs = sv(1, 1, 1, 1, 1); layer_outputs_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p1_l0_li_hold", 64'({layer_inputs_valid, layer_outputs_ready}), 64'd2);
            check("p1_l0_li_stable", 64'(layer_inputs), 64'(av(5, 4, 3, 2, 1)));
        end
        layer_outputs_valid = 1'b0; layer_inputs_ready = 1'b1;
        tick();
        layer_inputs_ready = 1'b0;
        check("p1_l0_wait", 64'({layer_inputs_valid, layer_outputs_ready}), 64'd1);
        // start offered during WAIT must be ignored
        start_inputs = av(7, 7, 7, 7, 7); start_inputs_valid = 1'b1; act_rd_addr = 2'd0;
        tick();
        start_inputs_valid = 1'b0;
        check("p1_ign_start", 64'({start_inputs_ready, layer_outputs_ready}), 64'd1);
        tick();
        check("p1_buf0_kept", 64'(act_rd_data), 64'(av(5, 4, 3, 2, 1)));

        layer_outputs = sv(3500, 3000, 2500, 2000, 1500); layer_outputs_valid = 1'b1;
        tick();
        layer_outputs_valid = 1'b0;
        check("p1_l1_num", 64'(layer_number), 64'd1);
        check("p1_l1_valids", 64'({layer_number_valid, layer_inputs_valid, layer_outputs_ready}), 64'd6);
        check("p1_l1_in", 64'(layer_inputs), 64'(exp_buf[1]));

        // ---- layer 1: inputs accepted before number
        layer_inputs_ready = 1'b1;
        tick();
        layer_inputs_ready = 1'b0;
        check("p1_l1_li_drop", 64'({layer_number_valid, layer_inputs_valid}), 64'd2);
        repeat (2) tick();
        check("p1_l1_ln_hold", 64'({layer_number_valid, layer_number, layer_outputs_ready}), 64'b1010);
        layer_number_ready = 1'b1;
        tick();
        layer_number_ready = 1'b0;
        check("p1_l1_wait", 64'({layer_number_valid, layer_outputs_ready}), 64'd1);
        layer_outputs = sv(2047, -1, 4, 1024, -2048); layer_outputs_valid = 1'b1;
        tick();
        layer_outputs_valid = 1'b0;
        check("p1_l2_num", 64'(layer_number), 64'd2);
        check("p1_l2_in", 64'(layer_inputs), 64'(exp_buf[2]));

        // ---- layer 2: both accepted on the same cycle
        layer_number_ready = 1'b1; layer_inputs_ready = 1'b1;
        tick();
        layer_number_ready = 1'b0; layer_inputs_ready = 1'b0;
        check("p1_l2_both", 64'({layer_number_valid, layer_inputs_valid, layer_outputs_ready}), 64'd1);
        layer_outputs = sv(8, 11, 2046, 2044, 3); layer_outputs_valid = 1'b1;
        tick();
        layer_outputs_valid = 1'b0;
        check("p1_res_valid", 64'(result_valid), 64'd1);
        check("p1_res", 64'(result), 64'(exp_buf[3]));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p1_res_hold", 64'({result_valid, busy}), 64'd3);
            check("p1_res_stable", 64'(result), 64'(exp_buf[3]));
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("p1_idle", 64'({result_valid, busy, start_inputs_ready}), 64'd1);
        for (int a = 0; a < 4; a++) begin
            act_rd_addr = 2'(a);
            tick();
            check($sformatf("p1_buf%0d", a), 64'(act_rd_data), 64'(exp_buf[a]));
        end

        // ---- pass 2: reset asserted during layer 1 WAIT
        layer_number_ready = 1'b1; layer_inputs_ready = 1'b1;
        start_inputs = av(9, 8, 7, 6, 5); start_inputs_valid = 1'b1;
        tick();
        start_inputs_valid = 1'b0;
        tick();
        check("p2_l0_wait", 64'(layer_outputs_ready), 64'd1);
        layer_outputs = sv(3500, 3000, 2500, 2000, 1500); layer_outputs_valid = 1'b1;
        tick();
        layer_outputs_valid = 1'b0;
        tick();
        check("p2_l1_wait", 64'({layer_outputs_ready, layer_number}), 64'b101);
        rst = 1'b0;
        #1;
        check("p2_rst_ctrl", 64'({busy, layer_number_valid, layer_inputs_valid, result_valid, layer_outputs_ready}), 64'd0);
        check("p2_rst_num", 64'(layer_number), 64'd0);
        check("p2_rst_data", 64'({result, layer_inputs}), 64'd0);
        check("p2_rst_rd", 64'(act_rd_data), 64'd0);
        tick();
        rst = 1'b1;
        act_rd_addr = 2'd1;
        tick();
        check("p2_buf1_clr", 64'(act_rd_data), 64'd0);
        act_rd_addr = 2'd0;
        tick();
        check("p2_buf0_clr", 64'(act_rd_data), 64'd0);

        // ---- pass 3: zero-wait handshakes, latency start + 3 x (issue + wait)
        layer_outputs = sv(8, 11, 2046, 2044, 3); layer_outputs_valid = 1'b1;
        start_inputs = av(1, 2, 3, 4, 5); start_inputs_valid = 1'b1;
        tick();
        start_inputs_valid = 1'b0;
        check("p3_l0", 64'({layer_number_valid, layer_number}), 64'b100);
        check("p3_l0_in", 64'(layer_inputs), 64'(av(1, 2, 3, 4, 5)));
        cyc = 1;
        while (!result_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        layer_outputs_valid = 1'b0;
        check("p3_latency", 64'(cyc), 64'd7);
        check("p3_res", 64'(result), 64'(exp_buf[3]));
        act_rd_addr = 2'd3;
        tick();
        check("p3_buf3_eq_res", 64'(act_rd_data), 64'(exp_buf[3]));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("p3_idle", 64'({busy, result_valid}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
